// File: rtl/twiddle_pkg.sv
// twiddle_pkg: shared types and elaboration helpers for the twiddle generator
package twiddle_pkg;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} seq_state_e;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int qdepth(input int n);
    return n / 4 + 1;
  endfunction
  function automatic logic stage_ok(input int s, input int log2n);
    return s < log2n;
  endfunction
endpackage

// File: rtl/twiddle_qrom.sv
// twiddle_qrom: quarter-wave cosine table with two registered read ports
module twiddle_qrom import twiddle_pkg::*; #(
  parameter int FFT_LEN = 512,
  parameter int WIDTH = 16,
  parameter string MEM_FILE = "cos_q.mem",
  localparam int AW = clog2(qdepth(FFT_LEN))
) (
  input  logic                    clk,
  input  logic                    en_i,
  input  logic [AW-1:0]           ra_i,
  input  logic [AW-1:0]           ia_i,
  output logic signed [WIDTH-1:0] cr_o,
  output logic signed [WIDTH-1:0] ci_o
);
  localparam int DEPTH = qdepth(FFT_LEN);
  function automatic longint qcos(input int i);
    longint pi_q = 64'sd3373259426;
    longint x = (2 * pi_q * i) / FFT_LEN;
    longint x2 = (x * x) >>> 30;
    longint term = 64'sd1 << 30;
    longint sum = term;
    for (int n = 1; n <= 12; n++) begin
      term = -((term * x2) >>> 30) / ((2 * n - 1) * (2 * n));
      sum += term;
    end
    return (sum * ((64'sd1 << (WIDTH - 1)) - 1) + (64'sd1 << 29)) >>> 30;
  endfunction
  logic [WIDTH-1:0] tab [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_e
    localparam logic [WIDTH-1:0] V = WIDTH'(qcos(i));
    assign tab[i] = V;
  end
  always_ff @(posedge clk) begin
    if (en_i) begin
      cr_o <= tab[ra_i];
      ci_o <= tab[ia_i];
    end
  end
endmodule

// File: rtl/twiddle_gen.sv
// twiddle_gen: streams one FFT stage of twiddle factors rebuilt from a quarter-wave table
module twiddle_gen import twiddle_pkg::*; #(
  parameter int FFT_LEN = 512,
  parameter int LOG2N = 9,
  parameter int WIDTH = 16,
  parameter string MEM_FILE = "cos_q.mem"
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LOG2N-1:0]   stage,
  input  logic               inverse,
  output logic               busy,
  output logic [WIDTH-1:0]   W_re,
  output logic [WIDTH-1:0]   W_im,
  output logic [LOG2N-2:0]   tw_index,
  output logic               tw_valid,
  input  logic               tw_ready,
  output logic               tw_last
);
  localparam int KW = LOG2N - 1;
  localparam int AW = clog2(qdepth(FFT_LEN));
  localparam logic [KW-1:0] HALF_M1 = KW'(FFT_LEN / 2 - 1);
  localparam logic [KW:0] HALF = (KW + 1)'(FFT_LEN / 2);
  localparam logic [KW:0] QTR = (KW + 1)'(FFT_LEN / 4);
  seq_state_e state_q;
  logic busy_q, inv_q, en, accept, hi_d;
  logic [KW-1:0] cnt_q, k_d;
  logic [LOG2N-1:0] s_q;
  logic [KW:0] kx, ra_x, ia_x;
  logic [AW-1:0] ra_d, ia_d, ra_q, ia_q;
  logic v1_q, last1_q, neg1_q, v2_q, last2_q, neg2_q;
  logic [KW-1:0] idx1_q, idx2_q, tw_index_q;
  logic signed [WIDTH-1:0] cr, ci, w_re_q, w_im_q;
  logic tw_valid_q, tw_last_q;
  // stall decode, start qualification, index generation and quadrant fold
  always_comb begin
    en = !(tw_valid_q && !tw_ready);
    accept = start && state_q == S_IDLE && stage_ok(int'(stage), LOG2N);
    k_d = (cnt_q & (HALF_M1 >> s_q)) << s_q;
    kx = {1'b0, k_d};
    hi_d = kx >= QTR;
    ra_x = hi_d ? HALF - kx : kx;
    ia_x = hi_d ? kx - QTR : QTR - kx;
    ra_d = AW'(ra_x);
    ia_d = AW'(ia_x);
  end
  // sequencer: issue N/2 indices, then wait for the last handshake to drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q <= 1'b0;
      cnt_q <= '0;
      s_q <= '0;
      inv_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          state_q <= S_RUN;
          busy_q <= 1'b1;
          cnt_q <= '0;
          s_q <= stage;
          inv_q <= inverse;
        end
        S_RUN: if (en) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == HALF_M1) state_q <= S_DRAIN;
        end
        S_DRAIN: if (tw_valid_q && tw_ready && tw_last_q) begin
          state_q <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  twiddle_qrom #(.FFT_LEN(FFT_LEN), .WIDTH(WIDTH), .MEM_FILE(MEM_FILE)) u_rom (
    .clk(clk), .en_i(en), .ra_i(ra_q), .ia_i(ia_q), .cr_o(cr), .ci_o(ci)
  );
  // fold, table-read tag and sign stages advance together under one enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {v1_q, last1_q, neg1_q, v2_q, last2_q, neg2_q} <= '0;
      {idx1_q, idx2_q, tw_index_q, ra_q, ia_q} <= '0;
      {tw_valid_q, tw_last_q, w_re_q, w_im_q} <= '0;
    end else if (en) begin
      v1_q <= state_q == S_RUN;
      last1_q <= cnt_q == HALF_M1;
      neg1_q <= hi_d;
      idx1_q <= k_d;
      ra_q <= ra_d;
      ia_q <= ia_d;
      v2_q <= v1_q;
      last2_q <= last1_q;
      neg2_q <= neg1_q;
      idx2_q <= idx1_q;
      tw_valid_q <= v2_q;
      tw_last_q <= v2_q && last2_q;
      if (v2_q) begin
        tw_index_q <= idx2_q;
        w_re_q <= neg2_q ? -cr : cr;
        w_im_q <= inv_q ? ci : -ci;
      end
    end
  end
  assign busy = busy_q;
  assign W_re = w_re_q;
  assign W_im = w_im_q;
  assign tw_index = tw_index_q;
  assign tw_valid = tw_valid_q;
  assign tw_last = tw_last_q;
endmodule
